// File: rtl/othello_pkg.sv
// Shared board/cell definitions for the flip scanner.
// Optional feature macro: FLIP_SCANNER_DRAW_EN (cell redraw handshake).
package othello_pkg;

  localparam int BOARD_DIM = 8;
  localparam int COORD_W   = $clog2(BOARD_DIM);
  localparam int ADDR_W    = 2 * COORD_W;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Two-bit signed deltas, order N NE E SE S SW W NW.
  localparam logic [1:0] DIR_DX [8] = '{
    2'b00, 2'b01, 2'b01, 2'b01,
    2'b00, 2'b11, 2'b11, 2'b11
  };
  localparam logic [1:0] DIR_DY [8] = '{
    2'b11, 2'b11, 2'b00, 2'b01,
    2'b01, 2'b01, 2'b00, 2'b11
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_ORIGIN,
    S_STEP,
    S_WAIT,
    S_FLIP,
    S_DRAW,
    S_PLACE,
    S_FIN
  } state_t;

  function automatic logic [1:0] own_cell(
    input logic player
  );
    return player ? CELL_WHITE : CELL_BLACK;
  endfunction

  function automatic logic [1:0] opp_cell(
    input logic player
  );
    return player ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/flip_scanner_board_step.sv
// Combinational neighbour lookup: one step from (x,y) along dir.
// Off-board is detected by the borrow/carry into the 4th coordinate bit.
module board_step
  import othello_pkg::*;
(
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [2:0]         i_dir,
  output logic [COORD_W-1:0] o_nx,
  output logic [COORD_W-1:0] o_ny,
  output logic               o_on_board,
  output logic [ADDR_W-1:0]  o_addr
);

  logic [1:0]       w_dx;
  logic [1:0]       w_dy;
  logic [COORD_W:0] w_sx;
  logic [COORD_W:0] w_sy;

  assign w_dx = DIR_DX[i_dir];
  assign w_dy = DIR_DY[i_dir];

  assign w_sx = {1'b0, i_x} + {{(COORD_W-1){w_dx[1]}}, w_dx};
  assign w_sy = {1'b0, i_y} + {{(COORD_W-1){w_dy[1]}}, w_dy};

  assign o_nx       = w_sx[COORD_W-1:0];
  assign o_ny       = w_sy[COORD_W-1:0];
  assign o_on_board = !w_sx[COORD_W] && !w_sy[COORD_W];
  assign o_addr     = {o_ny, o_nx};

endmodule

// File: rtl/flip_scanner.sv
// Othello move scanner: walks 8 directions, flips bracketed runs.
// Optional feature macro: FLIP_SCANNER_DRAW_EN (redraw handshake).
module flip_scanner
  import othello_pkg::*;
(
  input  logic               clk,
  input  logic               restart,
  input  logic               start,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               player,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [1:0]         rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [1:0]         wr_data,
  output logic               draw_req,
  input  logic               draw_ack,
  output logic [COORD_W-1:0] draw_x,
  output logic [COORD_W-1:0] draw_y,
  output logic               busy,
  output logic               done,
  output logic               valid_move,
  output logic [4:0]         flip_count
);

  state_t             r_state;
  logic               r_phase;
  logic [COORD_W-1:0] r_ox;
  logic [COORD_W-1:0] r_oy;
  logic               r_player;
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic [2:0]         r_dir;
  logic [2:0]         r_run;
  logic [4:0]         r_cnt;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [1:0]         r_wr_data;
  logic               r_busy;
  logic               r_done;
  logic               r_valid;

  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;
  logic               w_on;
  logic [ADDR_W-1:0]  w_addr;
  logic [1:0]         w_own;
  logic               w_rd_own;
  logic               w_rd_opp;
  logic               w_last_dir;

  board_step u_step (
    .i_x        (r_cx),
    .i_y        (r_cy),
    .i_dir      (r_dir),
    .o_nx       (w_nx),
    .o_ny       (w_ny),
    .o_on_board (w_on),
    .o_addr     (w_addr)
  );

  assign w_own      = own_cell(r_player);
  assign w_rd_own   = (rd_data == w_own);
  assign w_rd_opp   = (rd_data == opp_cell(r_player));
  assign w_last_dir = (r_dir == 3'd7);

`ifdef FLIP_SCANNER_DRAW_EN
  logic               r_draw_req;
  logic [COORD_W-1:0] r_draw_x;
  logic [COORD_W-1:0] r_draw_y;
  logic               r_placing;

  assign draw_req = r_draw_req;
  assign draw_x   = r_draw_x;
  assign draw_y   = r_draw_y;
`else
  logic w_unused;

  assign w_unused = draw_ack;
  assign draw_req = 1'b0;
  assign draw_x   = '0;
  assign draw_y   = '0;
`endif

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign valid_move = r_valid;
  assign flip_count = r_cnt;

  // Read address is presented in the issuing state; data returns next cycle.
  always_comb begin
    rd_addr = '0;
    if (r_state == S_ORIGIN)
      rd_addr = {r_oy, r_ox};
    else if (r_state == S_STEP && w_on)
      rd_addr = w_addr;
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (restart) begin
      r_state   <= S_IDLE;
      r_phase   <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_player  <= 1'b0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_dir     <= '0;
      r_run     <= '0;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= CELL_EMPTY;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
`ifdef FLIP_SCANNER_DRAW_EN
      r_draw_req <= 1'b0;
      r_draw_x   <= '0;
      r_draw_y   <= '0;
      r_placing  <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ox     <= pos_x;
            r_oy     <= pos_y;
            r_cx     <= pos_x;
            r_cy     <= pos_y;
            r_player <= player;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_dir    <= '0;
            r_run    <= '0;
            r_phase  <= 1'b0;
            r_busy   <= 1'b1;
`ifdef FLIP_SCANNER_DRAW_EN
            r_placing <= 1'b0;
`endif
            r_state  <= S_ORIGIN;
          end
        end
        S_ORIGIN: begin
          if (!r_phase)
            r_phase <= 1'b1;
          else if (rd_data == CELL_BLACK ||
                   rd_data == CELL_WHITE)
            r_state <= S_FIN;
          else
            r_state <= S_STEP;
        end
        S_STEP: begin
          if (w_on) begin
            r_cx    <= w_nx;
            r_cy    <= w_ny;
            r_state <= S_WAIT;
          end else begin
            r_dir   <= r_dir + 3'd1;
            r_cx    <= r_ox;
            r_cy    <= r_oy;
            r_run   <= '0;
            r_state <= w_last_dir ? S_PLACE : S_STEP;
          end
        end
        S_WAIT: begin
          if (w_rd_opp) begin
            r_run   <= r_run + 3'd1;
            r_state <= S_STEP;
          end else if (w_rd_own && r_run != 3'd0) begin
            r_cx    <= r_ox;
            r_cy    <= r_oy;
            r_state <= S_FLIP;
          end else begin
            r_dir   <= r_dir + 3'd1;
            r_cx    <= r_ox;
            r_cy    <= r_oy;
            r_run   <= '0;
            r_state <= w_last_dir ? S_PLACE : S_STEP;
          end
        end
        S_FLIP: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_addr;
          r_wr_data <= w_own;
          r_cx      <= w_nx;
          r_cy      <= w_ny;
          r_run     <= r_run - 3'd1;
          r_cnt     <= (r_cnt == 5'h1f) ? r_cnt : r_cnt + 5'd1;
`ifdef FLIP_SCANNER_DRAW_EN
          r_draw_req <= 1'b1;
          r_draw_x   <= w_nx;
          r_draw_y   <= w_ny;
          r_state    <= S_DRAW;
`else
          if (r_run == 3'd1) begin
            r_dir   <= r_dir + 3'd1;
            r_cx    <= r_ox;
            r_cy    <= r_oy;
            r_run   <= '0;
            r_state <= w_last_dir ? S_PLACE : S_STEP;
          end
`endif
        end
        S_DRAW: begin
`ifdef FLIP_SCANNER_DRAW_EN
          if (draw_ack) begin
            r_draw_req <= 1'b0;
            if (r_placing) begin
              r_state <= S_FIN;
            end else if (r_run == 3'd0) begin
              r_dir   <= r_dir + 3'd1;
              r_cx    <= r_ox;
              r_cy    <= r_oy;
              r_state <= w_last_dir ? S_PLACE : S_STEP;
            end else begin
              r_state <= S_FLIP;
            end
          end
`else
          r_state <= S_FIN;
`endif
        end
        S_PLACE: begin
          if (r_cnt != 5'd0) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= {r_oy, r_ox};
            r_wr_data <= w_own;
`ifdef FLIP_SCANNER_DRAW_EN
            r_draw_req <= 1'b1;
            r_draw_x   <= r_ox;
            r_draw_y   <= r_oy;
            r_placing  <= 1'b1;
            r_state    <= S_DRAW;
`else
            r_state <= S_FIN;
`endif
          end else begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_valid <= (r_cnt != 5'd0);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/flip_scanner.md
FLIP_SCANNER -- requirements
Module: flip_scanner

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk  in  1  rising-edge clock; restart  in  1  synchronous active-high reset.
REQ-002 SHALL have start  in  1  one-cycle move request, sampled only in IDLE.
REQ-003 SHALL have pos_x, pos_y  in  3 each  target cell, captured with start; player  in  1  0=black, 1=white, captured with start.
REQ-004 SHALL have rd_addr  out  6  board read address, where address = y*8+x; rd_data  in  2  cell value, valid the cycle after rd_addr is presented.
REQ-005 SHALL have wr_en  out  1, wr_addr  out  6, wr_data  out  2  single-cycle board write.
REQ-006 SHALL have draw_req  out  1, draw_ack  in  1, draw_x/draw_y  out  3 each  cell-redraw handshake to the cell drawer.
REQ-007 SHALL have busy  out  1; done  out  1  one-cycle pulse; valid_move  out  1  and flip_count  out  5, both held from done until the next start.

Function
REQ-010 Cell encoding SHALL be 00 empty, 01 black, 10 white; 11 SHALL be treated as empty.
REQ-011 FSM states SHALL be IDLE, ORIGIN, STEP, WAIT, FLIP, DRAW, PLACE, FIN.
REQ-012 IDLE: busy=0. start SHALL capture inputs, clear flip_count and direction index, set busy, and enter ORIGIN. start SHALL be ignored in every other state.
REQ-013 ORIGIN SHALL read the target cell. If it is non-empty, the FSM SHALL go to FIN with valid_move=0 and no writes.
REQ-014 Directions SHALL be scanned in order 0..7: N(0,-1), NE(+1,-1), E(+1,0), SE(+1,+1), S(0,+1), SW(-1,+1), W(-1,0), NW(-1,-1).
REQ-015 STEP SHALL compute the next coordinate. If that coordinate is off-board (x or y outside 0..7), it SHALL abandon the direction with no read issued. Otherwise it SHALL issue the read and go to WAIT.
REQ-016 In WAIT, an opponent cell SHALL increment the run count and return to STEP.
REQ-017 In WAIT, an own cell with run count ≥1 SHALL enter FLIP. An own cell with run count 0, or an empty cell, SHALL abandon the direction.
REQ-018 FLIP SHALL write player's colour to the run cells, one per cycle, walking from the cell nearest the origin outward. Each write SHALL increment flip_count.
REQ-019 After each FLIP write, the FSM SHALL visit DRAW (see REQ-040) before the next write.
REQ-020 Abandoning or completing a direction SHALL reset the run count and advance to the next direction. After direction 7 the FSM SHALL go to PLACE.
REQ-021 PLACE: if flip_count>0, the FSM SHALL write player's colour at the origin, followed by one DRAW for the origin. If flip_count=0, it SHALL make no write. It SHALL then go to FIN.
REQ-022 FIN SHALL pulse done for one cycle, set valid_move=(flip_count>0), clear busy, and return to IDLE.
REQ-023 The FSM SHALL never issue wr_en and a read dependent on that write in the same cycle; reads SHALL always observe prior writes.
REQ-024 flip_count SHALL NOT wrap, since 5 bits exceed the maximum legal flips (18).

Reset
REQ-030 On restart, all outputs SHALL be driven to 0, the state SHALL be IDLE, and captured registers SHALL be 0.
REQ-031 restart mid-scan SHALL suppress all further writes and draw_req from the next cycle on. Writes already made SHALL stand, and no done pulse SHALL be issued.

Configuration
REQ-040 With FLIP_SCANNER_DRAW_EN defined, DRAW SHALL assert draw_req with draw_x/draw_y of the last written cell and hold them stable until draw_ack is sampled high, then continue. draw_ack outside DRAW SHALL be ignored.
REQ-041 Without FLIP_SCANNER_DRAW_EN, draw_req SHALL be tied 0, draw_x/draw_y SHALL be 0, and DRAW SHALL be skipped (0 cycles).

Structure
REQ-050 Package othello_pkg SHALL hold the cell encoding constants, the direction delta table, the board dimension, the address width, and the FSM state enum.
REQ-051 A combinational sub-module board_step SHALL map (x, y, dir) to (nx, ny, on_board, addr). flip_scanner SHALL instantiate it once.

Verification
REQ-060 Opening board, with (3,3)=W, (4,3)=B, (3,4)=B, (4,4)=W. Black plays (3,2) -> one write of 01 at addr 27, then 01 at addr 19; flip_count=1, valid_move=1.
REQ-061 On the same opening board, black plays (0,0) -> no wr_en at any time; done pulses; valid_move=0, flip_count=0.
REQ-062 Target (3,3) already occupied -> done within 4 cycles of start; valid_move=0, no writes.
REQ-063 Row 0 = B W W W W W W (empty at (7,0)); black plays (7,0) -> 6 flips written at addrs 6..1 in that order, then origin addr 7; flip_count=6.
REQ-064 With DRAW_EN defined, draw_ack held low for 10 cycles on the first draw -> draw_req and draw_x/draw_y stay stable and no second write occurs; release -> scan resumes.
REQ-065 restart asserted 2 cycles into FLIP of REQ-063 -> from the next cycle wr_en=0, busy=0, draw_req=0, and no done pulse; a new start then completes normally.
